// File: rtl/tap_sequence_decoder.sv
// tap_sequence_decoder
//
// Groups debounced one-cycle press pulses into single, double or triple
// taps. The first press opens a sequence. Each further press restarts the
// quiet window. When the window runs out, the block emits a one-cycle
// tapValid pulse together with the number of taps.
//
// Optional feature macro: TAP_EARLY_EMIT_EN
//   defined   - the press that brings the count to MAX_TAPS emits at once.
//   undefined - the count saturates at MAX_TAPS, and extra presses are
//               ignored without restarting the window.
//
// Parameters:
//   TAP_WINDOW - quiet cycles that close a sequence (>= 2)
//   TIMER_W    - timer width, 2**TIMER_W > TAP_WINDOW
//   MAX_TAPS   - taps per sequence, 1..3
//
// Ports:
//   clock      in   rising-edge system clock
//   reset      in   synchronous, active-high reset
//   pressPulse in   press pulse from the debouncer (one count per high cycle)
//   tapValid   out  one-cycle pulse when a sequence completes
//   tapCount   out  taps in the completed sequence, held until next emission
//   busy       out  high while a sequence is open

module tap_sequence_decoder #(
  parameter int TAP_WINDOW = 30000000,
  parameter int TIMER_W    = 25,
  parameter int MAX_TAPS   = 3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       pressPulse,
  output logic       tapValid,
  output logic [1:0] tapCount,
  output logic       busy
);

  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TAP_WINDOW - 1);
  localparam logic [1:0]         TAPS_MAX   = 2'(MAX_TAPS);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    COUNTING = 2'd1,
    EMIT     = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [1:0]         taps_q, taps_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic               tap_valid_q, tap_valid_d;
  logic [1:0]         tap_count_q, tap_count_d;
  logic               busy_q, busy_d;

  // The tap count never goes past MAX_TAPS.
  function automatic logic [1:0] sat_inc_taps(input logic [1:0] t);
    return (t >= TAPS_MAX) ? TAPS_MAX : t + 2'd1;
  endfunction

  // The window timer stops at TAP_WINDOW-1 and never wraps.
  function automatic logic [TIMER_W-1:0] sat_inc_timer(input logic [TIMER_W-1:0] t);
    return (t >= TIMER_LAST) ? TIMER_LAST : t + TIMER_W'(1);
  endfunction

  always_comb begin
    state_d     = state_q;
    taps_d      = taps_q;
    timer_d     = timer_q;
    tap_valid_d = 1'b0;
    tap_count_d = tap_count_q;

    case (state_q)
      IDLE: begin
        if (pressPulse) begin
`ifdef TAP_EARLY_EMIT_EN
          // With MAX_TAPS of 1, the opening press already completes the sequence.
          if (TAPS_MAX == 2'd1) begin
            state_d     = EMIT;
            tap_valid_d = 1'b1;
            tap_count_d = TAPS_MAX;
            taps_d      = 2'd0;
            timer_d     = '0;
          end else begin
            state_d = COUNTING;
            taps_d  = 2'd1;
            timer_d = '0;
          end
`else
          state_d = COUNTING;
          taps_d  = 2'd1;
          timer_d = '0;
`endif
        end
      end

      COUNTING: begin
        // A press in the expiry cycle takes priority over the expiry.
        // Once the count is saturated, the press falls through to the timer
        // branches, so it does not restart the window.
        if (pressPulse && (taps_q < TAPS_MAX)) begin
          taps_d  = sat_inc_taps(taps_q);
          timer_d = '0;
`ifdef TAP_EARLY_EMIT_EN
          if (sat_inc_taps(taps_q) == TAPS_MAX) begin
            state_d     = EMIT;
            tap_valid_d = 1'b1;
            tap_count_d = TAPS_MAX;
            taps_d      = 2'd0;
          end
`endif
        end else if (timer_q == TIMER_LAST) begin
          state_d     = EMIT;
          tap_valid_d = 1'b1;
          tap_count_d = taps_q;
          taps_d      = 2'd0;
          timer_d     = '0;
        end else begin
          timer_d = sat_inc_timer(timer_q);
        end
      end

      EMIT: begin
        // A press arriving in the emission cycle opens the next sequence.
        // It does not emit straight away, so tapValid cannot be high on two
        // cycles in a row.
        state_d = IDLE;
        if (pressPulse) begin
          state_d = COUNTING;
          taps_d  = 2'd1;
          timer_d = '0;
        end
      end

      default: begin
        state_d = IDLE;
        taps_d  = 2'd0;
        timer_d = '0;
      end
    endcase

    busy_d = (state_d == COUNTING);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      taps_q      <= 2'd0;
      timer_q     <= '0;
      tap_valid_q <= 1'b0;
      tap_count_q <= 2'd0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      taps_q      <= taps_d;
      timer_q     <= timer_d;
      tap_valid_q <= tap_valid_d;
      tap_count_q <= tap_count_d;
      busy_q      <= busy_d;
    end
  end

  assign tapValid = tap_valid_q;
  assign tapCount = tap_count_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_tap_sequence_decoder.sv
module tb_tap_sequence_decoder;

  localparam int W    = 10;
  localparam int MAXT = 3;
`ifdef TAP_EARLY_EMIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       pressPulse = 1'b0;
  logic       tapValid;
  logic [1:0] tapCount;
  logic       busy;

  always #5 clock = ~clock;

  tap_sequence_decoder #(
    .TAP_WINDOW(W),
    .TIMER_W   (4),
    .MAX_TAPS  (MAXT)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .pressPulse(pressPulse),
    .tapValid  (tapValid),
    .tapCount  (tapCount),
    .busy      (busy)
  );

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, act, exp);
    end
  endtask

  // Model state: each counted press pushes out a deadline at press edge + W.
  bit m_open      = 1'b0;
  bit m_emit_prev = 1'b0;
  bit m_valid     = 1'b0;
  bit model_live  = 1'b0;
  int m_cnt       = 0;
  int m_count     = 0;
  int m_deadline  = 0;
  int m_edge      = 0;

  task automatic m_open_seq();
    m_open     = 1'b1;
    m_cnt      = 1;
    m_deadline = m_edge + W;
  endtask

  task automatic m_emit(input int c);
    m_open      = 1'b0;
    m_valid     = 1'b1;
    m_count     = c;
    m_emit_prev = 1'b1;
    m_cnt       = 0;
  endtask

  always @(posedge clock) begin
    m_edge++;
    if (reset) begin
      m_open      = 1'b0;
      m_emit_prev = 1'b0;
      m_valid     = 1'b0;
      m_cnt       = 0;
      m_count     = 0;
      model_live  = 1'b1;
    end else begin
      m_valid = 1'b0;
      if (m_emit_prev) begin
        m_emit_prev = 1'b0;
        if (pressPulse) m_open_seq();
      end else if (!m_open) begin
        if (pressPulse) begin
          if (EARLY && MAXT == 1) m_emit(1);
          else m_open_seq();
        end
      end else if (pressPulse && m_cnt < MAXT) begin
        m_cnt++;
        m_deadline = m_edge + W;
        if (EARLY && m_cnt == MAXT) m_emit(m_cnt);
      end else if (m_edge == m_deadline) begin
        m_emit(m_cnt);
      end
    end
  end

  always @(negedge clock) begin
    if (model_live) begin
      check("model_tapValid", tapValid, m_valid);
      check("model_tapCount", tapCount, m_count);
      check("model_busy", busy, m_open);
    end
  end

  // Edge t=0 is a reset edge. Pulses are listed by the edge that samples
  // them, and -1 marks an unused slot. Emissions e0 and e1 give literal
  // expectations, and busy is pinned to [b_lo,b_hi] when b_lo > 0.
  task automatic run_scn(input string name,
                         input int p0, input int p1, input int p2, input int p3,
                         input int rst_t,
                         input int e0_t, input int e0_c,
                         input int e1_t, input int e1_c,
                         input int b_lo, input int b_hi,
                         input int len);
    @(negedge clock);
    reset      = 1'b1;
    pressPulse = 1'b0;
    @(posedge clock);
    #1;
    check({name, "_rst_tapValid"}, tapValid, 0);
    check({name, "_rst_tapCount"}, tapCount, 0);
    check({name, "_rst_busy"}, busy, 0);
    for (int t = 1; t <= len; t++) begin
      @(negedge clock);
      reset      = (t == rst_t);
      pressPulse = (t == p0) || (t == p1) || (t == p2) || (t == p3);
      @(posedge clock);
      #1;
      check({name, "_tapValid"}, tapValid, (t == e0_t) || (t == e1_t));
      if (t == e0_t) check({name, "_tapCount0"}, tapCount, e0_c);
      if (t == e1_t) check({name, "_tapCount1"}, tapCount, e1_c);
      if (t == rst_t) begin
        check({name, "_midrst_busy"}, busy, 0);
        check({name, "_midrst_tapCount"}, tapCount, 0);
      end
      if (b_lo > 0) check({name, "_busy"}, busy, (t >= b_lo) && (t <= b_hi));
    end
    @(negedge clock);
    pressPulse = 1'b0;
    reset      = 1'b0;
  endtask

  initial begin
    run_scn("single",    5, -1, -1, -1, -1, 15, 1, -1, 0, 5, 14, 20);
    run_scn("double",    5, 12, -1, -1, -1, 22, 2, -1, 0, 0, 0, 26);
    run_scn("late2nd",   5, 14, -1, -1, -1, 24, 2, -1, 0, 0, 0, 28);
`ifdef TAP_EARLY_EMIT_EN
    run_scn("four",      5, 7, 9, 11, -1, 9, 3, 21, 1, 0, 0, 25);
`else
    run_scn("four",      5, 7, 9, 11, -1, 19, 3, -1, 0, 0, 0, 25);
`endif
    run_scn("midreset",  5, 20, -1, -1, 8, 30, 1, -1, 0, 0, 0, 34);
    run_scn("onexpiry",  5, 15, -1, -1, -1, 25, 2, -1, 0, 0, 0, 30);
    run_scn("emitpress", 5, 16, -1, -1, -1, 15, 1, 26, 1, 0, 0, 30);
    run_scn("heldhigh",  5, 6, -1, -1, -1, 16, 2, -1, 0, 0, 0, 20);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
